move_controller: RTL and testbench
==================================

# move_controller

Turn-sequencing stage directly upstream of the two per-player `position_decoder` instances. Accepts a move request (cell 0..8) from the input front end and validates it against the grid occupancy vector. A legal move is issued as a one-cycle write: 4-bit cell index plus exactly one player enable, feeding the decoders' `in`/`enable` pins. The block also tracks whose turn it is, counts moves, detects a draw, and enforces an optional per-turn timeout.

## Interface
- `TIMEOUT_CYCLES`, default 0: cycles a player may idle before the turn passes; 0 disables the timeout.
- `TMR_W`, default 32: width of the timeout counter; must hold `TIMEOUT_CYCLES-1`.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `new_game`  in  1  synchronous clear pulse; highest priority.
- `play_req`  in  1  one-cycle move request pulse.
- `sel_pos`  in  4  requested cell, 0..8; sampled with `play_req`.
- `occupied`  in  9  bit i set = cell i taken, from the grid registers.
- `game_over`  in  1  level from the winner detector.
- `pos_out`  out  4  cell index to both decoders' `in`.
- `p1_en`  out  1  enable to the player-1 decoder.
- `p2_en`  out  1  enable to the player-2 decoder.
- `player_turn`  out  1  0 = player 1, 1 = player 2.
- `move_count`  out  4  legal moves completed, 0..9.
- `busy`  out  1  high in every state except IDLE and END.
- `illegal_move`  out  1  one-cycle pulse on a rejected request.
- `timeout`  out  1  one-cycle pulse when the turn passes by timeout.
- `draw`  out  1  held high after the 9th move with no `game_over`.

## Operation
- States: IDLE, CHECK, WRITE, NEXT, END.
- IDLE:
  - `game_over`=1 -> END.
  - Otherwise, `play_req`=1 -> latch `sel_pos`, go to CHECK.
- CHECK: legal iff latched pos <= 8 and `occupied[pos]`=0.
  - Legal -> WRITE.
  - Illegal -> pulse `illegal_move`, return to IDLE; turn, count and timer are unchanged.
- WRITE:
  - `pos_out` = latched pos.
  - Exactly one enable high: `p1_en` if `player_turn`=0, otherwise `p2_en`.
  - Then go to NEXT.
- NEXT:
  - `move_count` += 1; toggle `player_turn`; clear the timer.
  - Go to END if `game_over`=1 or the new count = 9. When the count reaches 9 with `game_over`=0, set `draw`.
  - Otherwise go to IDLE.
- END: all requests ignored; stays until `new_game` or reset.
- `new_game` in any state forces one synchronous clear: state IDLE, turn 0, count 0, `draw` 0, timer 0, enables 0.
- `play_req` outside IDLE is dropped, not queued.
- A move in flight (CHECK/WRITE/NEXT) always completes. `game_over` is evaluated only in IDLE and NEXT.
- Timer:
  - Counts only in IDLE with `TIMEOUT_CYCLES`>0.
  - At `TIMEOUT_CYCLES-1`: pulse `timeout`, toggle the turn, clear the timer. `move_count` is unchanged.
  - If `play_req` arrives on the same cycle as expiry, the request wins and no timeout occurs.
- `pos_out` holds its last value when the enables are low.

## Timing
- Reset values: state IDLE; `pos_out` 0, `p1_en` 0, `p2_en` 0, `player_turn` 0, `move_count` 0, `busy` 0, `illegal_move` 0, `timeout` 0, `draw` 0; timer 0.
- All outputs are registered.
- `play_req` sampled at edge T:
  - Legal move: enable high during cycle T+2, `player_turn` and `move_count` update at T+3, ready for the next request at T+3.
  - Illegal move: `illegal_move` high during T+2; IDLE at T+2.
- Enables are never high for more than one consecutive cycle, and never both high.
- `rst_n` assertion mid-move: outputs reach their reset values immediately, and no enable glitch is permitted.

## Structure
- Shared package `ttt_pkg`:
  - state enum
  - `CELLS`=9, `POS_W`=4
  - `PLAYER1`=1'b0, `PLAYER2`=1'b1
- Sub-module `turn_timer`: parameterised counter with clear/enable inputs and an expire pulse.
- The FSM and counters live in `move_controller`.

## Test plan
- Reset, `play_req` with `sel_pos`=4, `occupied`=0 -> `pos_out`=4 and `p1_en`=1 on T+2 only; `player_turn`=1 and `move_count`=1 at T+3.
- `occupied`=9'h010, request pos 4 -> `illegal_move` pulse at T+2, no enable, turn still 0; a request for pos 10 gives the same result.
- Nine alternating legal moves with `game_over`=0 -> enables alternate p1/p2, `move_count`=9, `draw`=1, state END; a further `play_req` produces no response.
- `TIMEOUT_CYCLES`=16, no requests -> `timeout` pulse on the 16th IDLE cycle and the turn flips; `play_req` on the expiry cycle -> normal move, no timeout.
- `game_over` raised during WRITE -> the write completes and END follows NEXT; then `new_game` -> IDLE, turn 0, count 0, `draw` 0.
- `rst_n` low during WRITE -> enables drop immediately and all outputs reach their reset values.

Source files
------------

// File: rtl/ttt_pkg.sv
// Shared types and constants for the tic-tac-toe move sequencing logic.
package ttt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_WRITE,
    ST_NEXT,
    ST_END
  } state_t;

  localparam int CELLS = 9;
  localparam int POS_W = 4;

  localparam logic PLAYER1 = 1'b0;
  localparam logic PLAYER2 = 1'b1;

  localparam logic [POS_W-1:0] MAX_MOVES = POS_W'(CELLS);

endpackage

// File: rtl/turn_timer.sv
// Idle-cycle counter: counts while enabled, pulses expire on its final count.
// LIMIT of 0 disables expiry entirely.
module turn_timer #(
  parameter int LIMIT = 0,
  parameter int TMR_W = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic ACTIVE = (LIMIT > 0);
  localparam logic [TMR_W-1:0] LAST = TMR_W'(LIMIT - 1);

  logic [TMR_W-1:0] cnt_reg;
  logic             en_eff;

  assign en_eff = en & ACTIVE;
  assign expire = en_eff && (cnt_reg == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (clr || expire) begin
      cnt_reg <= '0;
    end else if (en_eff) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/move_controller.sv
// Turn sequencer: validates move requests against grid occupancy and issues
// a one-cycle write to the player decoders; tracks turn, count, draw, timeout.
module move_controller
  import ttt_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 0,
  parameter int TMR_W          = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             new_game,
  input  logic             play_req,
  input  logic [POS_W-1:0] sel_pos,
  input  logic [CELLS-1:0] occupied,
  input  logic             game_over,
  output logic [POS_W-1:0] pos_out,
  output logic             p1_en,
  output logic             p2_en,
  output logic             player_turn,
  output logic [POS_W-1:0] move_count,
  output logic             busy,
  output logic             illegal_move,
  output logic             timeout,
  output logic             draw
);

  state_t           state_reg;
  logic [POS_W-1:0] pos_reg;
  logic [CELLS-1:0] sel_onehot;
  logic             legal;
  logic             timer_en;
  logic             timer_clr;
  logic             expire;

  // Out-of-range positions decode to all zeros and are therefore illegal.
  generate
    for (genvar gi = 0; gi < CELLS; gi++) begin : g_decode
      assign sel_onehot[gi] = (pos_reg == POS_W'(gi));
    end
  endgenerate

  assign legal = (|sel_onehot) && ~(|(sel_onehot & occupied));

  // The timer holds on a request cycle so a request at expiry wins outright.
  assign timer_en  = (state_reg == ST_IDLE) && !game_over && !play_req && !new_game;
  assign timer_clr = new_game || (state_reg == ST_NEXT);

  turn_timer #(
    .LIMIT (TIMEOUT_CYCLES),
    .TMR_W (TMR_W)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (timer_clr),
    .en     (timer_en),
    .expire (expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      pos_reg      <= '0;
      pos_out      <= '0;
      p1_en        <= 1'b0;
      p2_en        <= 1'b0;
      player_turn  <= PLAYER1;
      move_count   <= '0;
      busy         <= 1'b0;
      illegal_move <= 1'b0;
      timeout      <= 1'b0;
      draw         <= 1'b0;
    end else begin
      p1_en        <= 1'b0;
      p2_en        <= 1'b0;
      illegal_move <= 1'b0;
      timeout      <= 1'b0;
      if (new_game) begin
        state_reg   <= ST_IDLE;
        player_turn <= PLAYER1;
        move_count  <= '0;
        draw        <= 1'b0;
        busy        <= 1'b0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (game_over) begin
              state_reg <= ST_END;
              busy      <= 1'b0;
            end else if (play_req) begin
              pos_reg   <= sel_pos;
              state_reg <= ST_CHECK;
              busy      <= 1'b1;
            end else if (expire) begin
              timeout     <= 1'b1;
              player_turn <= ~player_turn;
            end
          end
          ST_CHECK: begin
            if (legal) begin
              state_reg <= ST_WRITE;
              pos_out   <= pos_reg;
              p1_en     <= (player_turn == PLAYER1);
              p2_en     <= (player_turn == PLAYER2);
            end else begin
              state_reg    <= ST_IDLE;
              illegal_move <= 1'b1;
              busy         <= 1'b0;
            end
          end
          ST_WRITE: begin
            move_count  <= move_count + 1'b1;
            player_turn <= ~player_turn;
            state_reg   <= ST_NEXT;
          end
          ST_NEXT: begin
            busy <= 1'b0;
            if (game_over || (move_count == MAX_MOVES)) begin
              state_reg <= ST_END;
              draw      <= (move_count == MAX_MOVES) && !game_over;
            end else begin
              state_reg <= ST_IDLE;
            end
          end
          ST_END: begin
            state_reg <= ST_END;
          end
          default: begin
            state_reg <= ST_IDLE;
            busy      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_move_controller.sv
// Directed bench for move_controller: a vector table of moves plus
// hand-written sequences for end-of-game, reset and timeout behaviour.
module tb_move_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       new_game = 1'b0, play_req = 1'b0, game_over = 1'b0;
  logic [3:0] sel_pos = '0;
  logic [8:0] occupied = '0;
  logic [3:0] pos_out, move_count;
  logic       p1_en, p2_en, player_turn, busy, illegal_move, timeout, draw;

  logic       new_game_t = 1'b0, play_req_t = 1'b0, game_over_t = 1'b0;
  logic [3:0] sel_pos_t = '0;
  logic [8:0] occupied_t = '0;
  logic [3:0] pos_out_t, move_count_t;
  logic       p1_en_t, p2_en_t, player_turn_t, busy_t, illegal_move_t, timeout_t, draw_t;

  int checks = 0;
  int failures = 0;
  int en_viol = 0;
  logic prev_en = 1'b0;

  always #5 clk = ~clk;

  move_controller #(.TIMEOUT_CYCLES(0), .TMR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .new_game(new_game), .play_req(play_req),
    .sel_pos(sel_pos), .occupied(occupied), .game_over(game_over),
    .pos_out(pos_out), .p1_en(p1_en), .p2_en(p2_en), .player_turn(player_turn),
    .move_count(move_count), .busy(busy), .illegal_move(illegal_move),
    .timeout(timeout), .draw(draw)
  );

  move_controller #(.TIMEOUT_CYCLES(16), .TMR_W(8)) dut_t (
    .clk(clk), .rst_n(rst_n), .new_game(new_game_t), .play_req(play_req_t),
    .sel_pos(sel_pos_t), .occupied(occupied_t), .game_over(game_over_t),
    .pos_out(pos_out_t), .p1_en(p1_en_t), .p2_en(p2_en_t), .player_turn(player_turn_t),
    .move_count(move_count_t), .busy(busy_t), .illegal_move(illegal_move_t),
    .timeout(timeout_t), .draw(draw_t)
  );

  // Enables must never overlap nor stay high two cycles running.
  always @(negedge clk) begin
    if (p1_en && p2_en) en_viol++;
    if ((p1_en || p2_en) && prev_en) en_viol++;
    prev_en = p1_en || p2_en;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0] pos;
    logic [8:0] occ;
    logic       legal;
    logic       exp_p1;
    logic       exp_p2;
    logic       exp_turn;
    logic [3:0] exp_count;
    logic       exp_draw;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];

  initial begin
    logic [3:0] last_pos;
    int seen;

    vecs[0]  = '{4'd4,  9'h010, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0};
    vecs[1]  = '{4'd10, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0};
    vecs[2]  = '{4'd4,  9'h000, 1'b1, 1'b1, 1'b0, 1'b1, 4'd1, 1'b0};
    vecs[3]  = '{4'd0,  9'h010, 1'b1, 1'b0, 1'b1, 1'b0, 4'd2, 1'b0};
    vecs[4]  = '{4'd0,  9'h011, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 1'b0};
    vecs[5]  = '{4'd8,  9'h011, 1'b1, 1'b1, 1'b0, 1'b1, 4'd3, 1'b0};
    vecs[6]  = '{4'd2,  9'h111, 1'b1, 1'b0, 1'b1, 1'b0, 4'd4, 1'b0};
    vecs[7]  = '{4'd6,  9'h115, 1'b1, 1'b1, 1'b0, 1'b1, 4'd5, 1'b0};
    vecs[8]  = '{4'd3,  9'h155, 1'b1, 1'b0, 1'b1, 1'b0, 4'd6, 1'b0};
    vecs[9]  = '{4'd5,  9'h15D, 1'b1, 1'b1, 1'b0, 1'b1, 4'd7, 1'b0};
    vecs[10] = '{4'd7,  9'h17D, 1'b1, 1'b0, 1'b1, 1'b0, 4'd8, 1'b0};
    vecs[11] = '{4'd1,  9'h1FD, 1'b1, 1'b1, 1'b0, 1'b1, 4'd9, 1'b1};

    repeat (2) @(posedge clk);
    #1;
    check("rst_pos_out", pos_out, 0);
    check("rst_enables", {p1_en, p2_en}, 0);
    check("rst_turn_count", {player_turn, move_count}, 0);
    check("rst_flags", {busy, illegal_move, timeout, draw}, 0);
    rst_n = 1'b1;
    tick;

    last_pos = 4'd0;
    for (int i = 0; i < NV; i++) begin
      sel_pos = vecs[i].pos;
      occupied = vecs[i].occ;
      play_req = 1'b1;
      tick;
      play_req = 1'b0;
      check("vec_busy_check", busy, 1);
      tick;
      check("vec_illegal", illegal_move, !vecs[i].legal);
      check("vec_enables", {p1_en, p2_en}, {vecs[i].exp_p1, vecs[i].exp_p2});
      if (vecs[i].legal) last_pos = vecs[i].pos;
      check("vec_pos_out", pos_out, last_pos);
      check("vec_busy_write", busy, vecs[i].legal);
      tick;
      check("vec_en_drop", {p1_en, p2_en, illegal_move}, 0);
      check("vec_turn", player_turn, vecs[i].exp_turn);
      check("vec_count", move_count, vecs[i].exp_count);
      tick;
      check("vec_draw", draw, vecs[i].exp_draw);
      check("vec_busy_done", busy, 0);
      $display("vec %0d pos=%0d occ=%03h legal=%0b turn=%0b count=%0d draw=%0b",
               i, vecs[i].pos, vecs[i].occ, vecs[i].legal, player_turn, move_count, draw);
    end

    // END after draw: a request that would be legal in IDLE is ignored.
    occupied = 9'h000;
    sel_pos = 4'd0;
    play_req = 1'b1;
    tick;
    play_req = 1'b0;
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      seen += int'(p1_en) + int'(p2_en) + int'(illegal_move) + int'(busy);
      tick;
    end
    check("end_ignores_req", seen, 0);
    check("end_count_held", move_count, 9);
    $display("seq end_drop count=%0d draw=%0b", move_count, draw);

    new_game = 1'b1;
    tick;
    new_game = 1'b0;
    check("newgame_state", {player_turn, move_count, draw, busy}, 0);
    $display("seq new_game turn=%0b count=%0d draw=%0b", player_turn, move_count, draw);

    // game_over during WRITE: move completes, then END.
    sel_pos = 4'd0;
    play_req = 1'b1;
    tick;
    play_req = 1'b0;
    tick;
    check("go_write_en", {p1_en, p2_en}, 2'b10);
    game_over = 1'b1;
    tick;
    check("go_next_count", {player_turn, move_count}, {1'b1, 4'd1});
    tick;
    check("go_end_flags", {busy, draw}, 0);
    game_over = 1'b0;
    sel_pos = 4'd1;
    play_req = 1'b1;
    tick;
    play_req = 1'b0;
    seen = 0;
    for (int k = 0; k < 3; k++) begin
      seen += int'(p1_en) + int'(p2_en) + int'(illegal_move) + int'(busy);
      tick;
    end
    check("go_end_ignores", seen, 0);
    check("go_end_count", move_count, 1);
    new_game = 1'b1;
    tick;
    new_game = 1'b0;
    check("go_newgame", {player_turn, move_count, draw, busy}, 0);
    $display("seq game_over_in_write turn=%0b count=%0d", player_turn, move_count);

    // Reset asserted while player 2's write is on the wire.
    sel_pos = 4'd3;
    play_req = 1'b1;
    tick;
    play_req = 1'b0;
    repeat (3) tick;
    occupied = 9'h008;
    sel_pos = 4'd5;
    play_req = 1'b1;
    tick;
    play_req = 1'b0;
    tick;
    check("rstw_p2_en", {p1_en, p2_en, pos_out}, {1'b0, 1'b1, 4'd5});
    #2 rst_n = 1'b0;
    #1;
    check("rstw_enables", {p1_en, p2_en}, 0);
    check("rstw_outputs", {pos_out, player_turn, move_count, busy, draw}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick;
    check("rstw_after", {p1_en, p2_en, busy, move_count}, 0);
    $display("seq reset_in_write pos=%0d turn=%0b count=%0d", pos_out, player_turn, move_count);

    // Timeout instance: expiry after 16 idle cycles, then request on expiry.
    new_game_t = 1'b1;
    tick;
    new_game_t = 1'b0;
    seen = 0;
    for (int k = 0; k < 15; k++) begin
      tick;
      seen += int'(timeout_t);
    end
    check("to_early", seen, 0);
    tick;
    check("to_pulse", timeout_t, 1);
    check("to_turn", {player_turn_t, move_count_t}, {1'b1, 4'd0});
    seen = 0;
    for (int k = 0; k < 15; k++) begin
      tick;
      seen += int'(timeout_t);
    end
    check("to_single_pulse", seen, 0);
    sel_pos_t = 4'd2;
    play_req_t = 1'b1;
    tick;
    play_req_t = 1'b0;
    check("to_req_wins", {timeout_t, busy_t, player_turn_t}, {1'b0, 1'b1, 1'b1});
    tick;
    check("to_req_write", {p1_en_t, p2_en_t, pos_out_t}, {1'b0, 1'b1, 4'd2});
    tick;
    check("to_req_next", {player_turn_t, move_count_t, timeout_t}, {1'b0, 4'd1, 1'b0});
    $display("seq timeout turn=%0b count=%0d", player_turn_t, move_count_t);

    check("enable_exclusive", en_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
